// File: rtl/seq_generator_if.sv
// Parallel-word handshake plus the serial frame outputs of the 101-stream transmitter.
interface seq_generator_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic              a;
    logic              busy;
    logic              frame_start;
    logic              last_bit;

    modport master (
        output din, din_valid,
        input  din_ready, a, busy, frame_start, last_bit
    );

    modport slave (
        input  din, din_valid,
        output din_ready, a, busy, frame_start, last_bit
    );
endinterface

// File: rtl/seq_generator.sv
// Serial frame transmitter: "101" preamble, DATA_W payload bits MSB-first, GAP idle zeros.
// state  | meaning
// IDLE   | din_ready high, a=0, waiting for din_valid
// PRE    | three preamble cycles driving 1,0,1
// DATA   | payload bits shifted out MSB-first
// GAP    | trailing idle zeros before returning to IDLE
module seq_generator #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic           clk,
    input  logic           reset,
    seq_generator_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

    localparam logic [4:0] PRE_LAST  = 5'd2;
    localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);
    localparam logic [4:0] GAP_LAST  = (GAP > 0) ? 5'(GAP - 1) : 5'd0;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              a_q, a_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              fs_q, fs_d;
    logic              lb_q, lb_d;
    logic              accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        shreg_d = shreg_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = 5'd0;
                if (bus.din_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = S_PRE;
                    shreg_d = bus.din;
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = 5'd0;
                end
            end
            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = (GAP > 0) ? S_GAP : S_IDLE;
                    cnt_d   = 5'd0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase

        // Outputs are computed for the state being entered so they leave straight from flops.
        a_d = 1'b0;
        if (state_d == S_PRE) begin
            a_d = (cnt_d != 5'd1);
        end else if (state_d == S_DATA) begin
            a_d     = shreg_q[DATA_W-1];
            shreg_d = shreg_q << 1;
        end
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
        fs_d    = accept;
        lb_d    = (state_d == S_DATA) && (cnt_d == DATA_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            shreg_q <= '0;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            fs_q    <= 1'b0;
            lb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            a_q     <= a_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            fs_q    <= fs_d;
            lb_q    <= lb_d;
        end
    end

    assign bus.a           = a_q;
    assign bus.busy        = busy_q;
    assign bus.din_ready   = ready_q;
    assign bus.frame_start = fs_q;
    assign bus.last_bit    = lb_q;
endmodule

// File: tb/tb_seq_generator.sv
// Directed bench for seq_generator: default instance plus a DATA_W=1, GAP=0 instance.
module tb_seq_generator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_generator_if #(.DATA_W(8)) bus0 ();
    seq_generator_if #(.DATA_W(1)) bus1 ();

    seq_generator #(.DATA_W(8), .GAP(2)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    seq_generator #(.DATA_W(1), .GAP(0)) u1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct packed {
        logic a;
        logic fs;
        logic lb;
        logic busy;
        logic rdy;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   acc0[$];
    int   acc1[$];
    int   det[$];
    int   cyc = 0;
    int   pos;
    logic [2:0] hist;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus0.din_valid && bus0.din_ready) acc0.push_back(cyc);
        if (bus1.din_valid && bus1.din_ready) acc1.push_back(cyc);
    end

    function automatic exp_t mk(logic a, logic fs, logic lb, logic busy, logic rdy);
        exp_t e;
        e.a = a; e.fs = fs; e.lb = lb; e.busy = busy; e.rdy = rdy;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        vectors++;
        assert (obs === expd) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
        end
    endtask

    // Expected behaviour of the default instance for one frame, including the trailing IDLE cycle.
    task automatic push_frame0(input logic [7:0] d);
        sb0.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        sb0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        sb0.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        for (int i = 7; i >= 0; i--) sb0.push_back(mk(d[i], 1'b0, (i == 0), 1'b1, 1'b0));
        for (int g = 0; g < 2; g++) sb0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        sb0.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic push_frame1(input logic d);
        sb1.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        sb1.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        sb1.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        sb1.push_back(mk(d,    1'b0, 1'b1, 1'b1, 1'b0));
        sb1.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("u0.a",           bus0.a,           e.a);
            chk("u0.frame_start", bus0.frame_start, e.fs);
            chk("u0.last_bit",    bus0.last_bit,    e.lb);
            chk("u0.busy",        bus0.busy,        e.busy);
            chk("u0.din_ready",   bus0.din_ready,   e.rdy);
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("u1.a",           bus1.a,           e.a);
            chk("u1.frame_start", bus1.frame_start, e.fs);
            chk("u1.last_bit",    bus1.last_bit,    e.lb);
            chk("u1.busy",        bus1.busy,        e.busy);
            chk("u1.din_ready",   bus1.din_ready,   e.rdy);
        end
        hist = {hist[1:0], bus0.a};
        pos++;
        if (hist == 3'b101) det.push_back(pos);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a"},           bus0.a,           32'd0);
        chk({tag, ".busy"},        bus0.busy,        32'd0);
        chk({tag, ".din_ready"},   bus0.din_ready,   32'd0);
        chk({tag, ".frame_start"}, bus0.frame_start, 32'd0);
        chk({tag, ".last_bit"},    bus0.last_bit,    32'd0);
    endtask

    initial begin
        bus0.din = 8'h00; bus0.din_valid = 1'b0;
        bus1.din = 1'b0;  bus1.din_valid = 1'b0;
        hist = 3'b000; pos = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk_all_zero("rst");
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rel.din_ready", bus0.din_ready, 32'd1);
        chk("rel.a",         bus0.a,         32'd0);

        // Single frame 8'hC3, with a din_valid pulse and din change mid-frame that must be ignored.
        bus0.din = 8'hC3; bus0.din_valid = 1'b1;
        push_frame0(8'hC3);
        step();
        bus0.din_valid = 1'b0;
        for (int i = 1; i < 14; i++) begin
            if (i == 4) begin bus0.din = 8'hFF; bus0.din_valid = 1'b1; end
            if (i == 5) bus0.din_valid = 1'b0;
            step();
        end
        chk("hyg.accepts", acc0.size(), 32'd1);

        // Back-to-back: A5 then 00 with din_valid held high.
        bus0.din = 8'hA5; bus0.din_valid = 1'b1;
        push_frame0(8'hA5);
        push_frame0(8'h00);
        step();
        bus0.din = 8'h00;
        for (int i = 1; i < 15; i++) step();
        bus0.din_valid = 1'b0;
        for (int i = 15; i < 28; i++) step();
        chk("b2b.accepts", acc0.size(), 32'd3);
        if (acc0.size() == 3) chk("b2b.spacing", acc0[2] - acc0[1], 32'd14);

        // Loopback: 8'h40 gives overlapping 101 matches at stream bits 3 and 5.
        hist = 3'b000; pos = 0; det.delete();
        bus0.din = 8'h40; bus0.din_valid = 1'b1;
        push_frame0(8'h40);
        step();
        bus0.din_valid = 1'b0;
        for (int i = 1; i < 14; i++) step();
        chk("loop.count", det.size(), 32'd2);
        if (det.size() == 2) begin
            chk("loop.det0", det[0], 32'd3);
            chk("loop.det1", det[1], 32'd5);
        end

        // Reset asserted mid-DATA discards the frame immediately.
        bus0.din = 8'hFF; bus0.din_valid = 1'b1;
        push_frame0(8'hFF);
        step();
        bus0.din_valid = 1'b0;
        for (int i = 1; i < 6; i++) step();
        reset = 1'b0;
        #1 chk_all_zero("midrst");
        sb0.delete();
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst.rel.din_ready", bus0.din_ready, 32'd1);
        chk("midrst.rel.a",         bus0.a,         32'd0);
        chk("midrst.rel.busy",      bus0.busy,      32'd0);

        // DATA_W=1, GAP=0 instance, two frames with din_valid held.
        bus1.din = 1'b1; bus1.din_valid = 1'b1;
        push_frame1(1'b1);
        push_frame1(1'b1);
        step();
        for (int i = 1; i < 6; i++) step();
        bus1.din_valid = 1'b0;
        for (int i = 6; i < 10; i++) step();
        chk("sweep.accepts", acc1.size(), 32'd2);
        if (acc1.size() == 2) chk("sweep.spacing", acc1[1] - acc1[0], 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
